// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types: LLR width/type and the inverse-scaler FSM state encoding.
package ldpc_pkg;

  localparam int unsigned LLR_W = 9;

  typedef logic signed [LLR_W-1:0] llr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_scl_state_t;

endpackage : ldpc_pkg

// File: rtl/div3_step.sv
// One restoring-division iteration by 3: shift a dividend bit into the 2-bit remainder,
// subtract 3 when it fits and emit the quotient bit.
module div3_step (
  input  logic [1:0] rem_i,
  input  logic       bit_i,
  output logic [1:0] rem_c_o,
  output logic       qbit_c_o
);

  logic [2:0] trial;
  logic [2:0] diff;

  always_comb begin
    trial    = {rem_i, bit_i};
    diff     = trial - 3'd3;
    qbit_c_o = (trial >= 3'd3);
    rem_c_o  = qbit_c_o ? diff[1:0] : trial[1:0];
  end

endmodule : div3_step

// File: rtl/llr_inv_scaler.sv
// Undoes the x0.75 check-node scaling: o_data = sign(x)*floor(4|x|/3), computed with a
// serial MSB-first divide-by-3, with optional symmetric saturation and a valid/ready handshake.
module llr_inv_scaler
  import ldpc_pkg::*;
#(
  parameter int unsigned W      = 9,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_sat
);

  localparam int unsigned DW = W + 2;
  localparam int unsigned CW = $clog2(W + 3);
  localparam logic [CW-1:0] LAST_IT = CW'(W + 1);
  localparam logic [W-1:0]  MAX_W   = W'((1 << (W - 1)) - 1);
  localparam logic [DW-1:0] MAX_Q   = DW'((1 << (W - 1)) - 1);

  inv_scl_state_t state_q, state_d;
  logic [DW-1:0]  dvd_q, dvd_d;
  logic [DW-1:0]  quo_q, quo_d;
  logic [1:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           zero_q, zero_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;
  logic           sat_q, sat_d;

  logic [W-1:0]   abs_x;
  logic [1:0]     step_rem;
  logic           step_q;
  logic [DW-1:0]  quo_next;
  logic [W-1:0]   fmt_data;
  logic           fmt_sat;
  logic [W-1:0]   mag_w;
  logic           ovf;

  // Unsigned magnitude: the most negative code maps to 2^(W-1) without overflow.
  always_comb begin
    abs_x = i_data[W-1] ? W'(-i_data) : i_data;
  end

  div3_step u_step (
    .rem_i    (rem_q),
    .bit_i    (dvd_q[DW-1]),
    .rem_c_o  (step_rem),
    .qbit_c_o (step_q)
  );

  // Result formatting from the quotient including the final iteration's bit.
  always_comb begin
    quo_next = {quo_q[DW-2:0], step_q};
    mag_w    = quo_next[W-1:0];
    ovf      = (quo_next > MAX_Q);
    fmt_data = '0;
    fmt_sat  = 1'b0;
    if (zero_q) begin
      fmt_data = '0;
      fmt_sat  = 1'b0;
    end else if (SAT_EN && ovf) begin
      fmt_data = neg_q ? W'(-MAX_W) : MAX_W;
      fmt_sat  = 1'b1;
    end else begin
      fmt_data = neg_q ? W'(-mag_w) : mag_w;
      fmt_sat  = ovf;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    data_d  = data_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          state_d = BUSY;
          dvd_d   = {abs_x, 2'b00};
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          neg_d   = i_data[W-1];
          zero_d  = (i_data == '0);
        end
      end
      BUSY: begin
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        quo_d = quo_next;
        rem_d = step_rem;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == LAST_IT) begin
          state_d = DONE;
          data_d  = fmt_data;
          sat_d   = fmt_sat;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_sat   = sat_q;

endmodule : llr_inv_scaler

// File: tb/tb_llr_inv_scaler.sv
// Directed and exhaustive checks of llr_inv_scaler (W=9, saturating): results, latency,
// back-pressure hold, ignored i_valid, mid-operation reset and throughput.
module tb_llr_inv_scaler;

  localparam int unsigned W   = 9;
  localparam int          LAT = 11;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_sat;

  int total;
  int bad;

  llr_inv_scaler #(.W(W), .SAT_EN(1'b1)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sat   (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic         s;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: sign*floor(4|x|/3), saturated to +-255.
  task automatic ref_model(input logic [W-1:0] x, output logic [W-1:0] d, output logic s);
    int v;
    int m;
    int q;
    v = int'($signed(x));
    m = (v < 0) ? -v : v;
    q = (4 * m) / 3;
    s = 1'b0;
    if (q > 255) begin
      q = 255;
      s = 1'b1;
    end
    d = W'((v < 0) ? -q : q);
  endtask

  // Returns cycles from accept edge until o_valid is seen (capped at 40).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input logic [W-1:0] x, output logic [W-1:0] d, output logic s,
                         output int lat);
    int guard;
    guard = 0;
    while (o_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    i_valid = 1'b1;
    i_data  = x;
    tick();
    i_valid = 1'b0;
    i_data  = ~x;
    wait_valid(lat);
    d = o_data;
    s = o_sat;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic         s;
    logic [W-1:0] ed;
    logic         es;
    int           lat;
    int           seen;

    total   = 0;
    bad     = 0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    rst_n   = 1'b0;

    vecs[0]  = '{x: 9'd3,   d: 9'd4,   s: 1'b0};
    vecs[1]  = '{x: 9'h1FF, d: 9'h1FF, s: 1'b0};
    vecs[2]  = '{x: 9'd191, d: 9'd254, s: 1'b0};
    vecs[3]  = '{x: 9'd0,   d: 9'd0,   s: 1'b0};
    vecs[4]  = '{x: 9'd192, d: 9'd255, s: 1'b1};
    vecs[5]  = '{x: 9'h100, d: 9'h101, s: 1'b1};
    vecs[6]  = '{x: 9'd6,   d: 9'd8,   s: 1'b0};
    vecs[7]  = '{x: 9'h1FD, d: 9'h1FC, s: 1'b0};
    vecs[8]  = '{x: 9'd255, d: 9'd255, s: 1'b1};
    vecs[9]  = '{x: 9'h141, d: 9'h102, s: 1'b0};
    vecs[10] = '{x: 9'd1,   d: 9'd1,   s: 1'b0};
    vecs[11] = '{x: 9'd2,   d: 9'd2,   s: 1'b0};
    vecs[12] = '{x: 9'h1FE, d: 9'h1FE, s: 1'b0};
    vecs[13] = '{x: 9'd190, d: 9'd253, s: 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_sat",   32'(o_sat),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(o_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_one(vecs[i].x, d, s, lat);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("vec%0d_sat", i),  32'(s), 32'(vecs[i].s));
      chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(LAT));
    end

    // Back-pressure hold with an ignored i_valid pulse: 100 -> 133
    i_valid = 1'b1;
    i_data  = 9'd100;
    tick();
    i_valid = 1'b0;
    wait_valid(lat);
    chk("stall_lat", 32'(lat), 32'(LAT));
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        i_valid = 1'b1;
        i_data  = 9'h155;
      end else begin
        i_valid = 1'b0;
        i_data  = 9'd7;
      end
      chk($sformatf("stall%0d_data", c),  32'(o_data),  32'd133);
      chk($sformatf("stall%0d_sat", c),   32'(o_sat),   32'd0);
      chk($sformatf("stall%0d_ready", c), 32'(o_ready), 32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(o_valid), 32'd1);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("stall_post_valid", 32'(o_valid), 32'd0);
    chk("stall_post_ready", 32'(o_ready), 32'd1);
    repeat (3) tick();
    chk("stall_no_extra", 32'(o_valid), 32'd0);

    // Reset asserted at iteration 6 discards the operation
    i_valid = 1'b1;
    i_data  = 9'd3;
    tick();
    i_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(o_ready), 32'd1);
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    seen = 0;
    i_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (o_valid === 1'b1) seen++;
      tick();
    end
    i_ready = 1'b0;
    chk("post_rst_no_result", 32'(seen), 32'd0);
    run_one(9'd6, d, s, lat);
    chk("post_rst_data", 32'(d),   32'd8);
    chk("post_rst_sat",  32'(s),   32'd0);
    chk("post_rst_lat",  32'(lat), 32'(LAT));

    // Exhaustive sweep, i_valid and i_ready held high
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] x;
      x = W'(i);
      chk($sformatf("sweep%0d_ready", i), 32'(o_ready), 32'd1);
      i_data = x;
      tick();
      i_data = ~x;
      wait_valid(lat);
      ref_model(x, ed, es);
      chk($sformatf("sweep%0d_lat", i),  32'(lat),    32'(LAT));
      chk($sformatf("sweep%0d_data", i), 32'(o_data), 32'(ed));
      chk($sformatf("sweep%0d_sat", i),  32'(o_sat),  32'(es));
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_llr_inv_scaler
